// File: rtl/lm_sm_sequencer_if.sv
// Memory beat handshake between the LM/SM sequencer (master) and the data memory (slave).
interface lm_sm_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_ack;

    modport master (output mem_req, output mem_we, output mem_addr, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_addr, output mem_ack);
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks the register mask lowest bit first,
// issuing one req/ack memory beat per selected register.
module lm_sm_sequencer #(
    parameter int         DATA_W = 16,
    parameter int         NREGS  = 8,
    parameter int         REG_AW = 3,
    parameter logic [3:0] OPC_LM = 4'b0110,
    parameter logic [3:0] OPC_SM = 4'b0111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     ir,
    input  logic [DATA_W-1:0]     base_addr,
    input  logic                  flush,
    output logic                  ready,
    output logic                  busy,
    lm_sm_sequencer_if.master     mem,
    output logic [REG_AW-1:0]     reg_addr,
    output logic                  rf_we,
    output logic                  done,
    output logic [REG_AW:0]       xfer_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [NREGS-1:0]  mask_q,   mask_d;
    logic [DATA_W-1:0] base_q,   base_d;
    logic [DATA_W-1:0] offset_q, offset_d;
    logic              op_sm_q,  op_sm_d;
    logic [REG_AW:0]   count_q,  count_d;

    logic [3:0]        opcode;
    logic              opc_ok;
    logic              beat_ack;
    logic [REG_AW-1:0] low_idx;
    logic [NREGS-1:0]  mask_rest;

    // Lowest set bit of the remaining mask selects the register for this beat.
    always_comb begin
        low_idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = REG_AW'(i);
        end
    end

    always_comb begin
        opcode    = ir[DATA_W-1 -: 4];
        opc_ok    = (opcode == OPC_LM) || (opcode == OPC_SM);
        beat_ack  = (state_q == S_XFER) && mem.mem_ack;
        mask_rest = mask_q & (mask_q - NREGS'(1));

        state_d  = state_q;
        mask_d   = mask_q;
        base_d   = base_q;
        offset_d = offset_q;
        op_sm_d  = op_sm_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush && opc_ok) begin
                    mask_d   = ir[NREGS-1:0];
                    base_d   = base_addr;
                    offset_d = '0;
                    count_d  = '0;
                    op_sm_d  = (opcode == OPC_SM);
                    state_d  = (|ir[NREGS-1:0]) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                if (beat_ack) begin
                    mask_d   = mask_rest;
                    offset_d = offset_q + DATA_W'(1);
                    count_d  = count_q + (REG_AW+1)'(1);
                end
                // A flushed beat that is acked still retires; only the sequence is dropped.
                if (flush)
                    state_d = S_IDLE;
                else if (beat_ack && (mask_rest == '0))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            base_q   <= '0;
            offset_q <= '0;
            op_sm_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            op_sm_q  <= op_sm_d;
            count_q  <= count_d;
        end
    end

    assign ready        = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign mem.mem_req  = (state_q == S_XFER);
    assign mem.mem_we   = (state_q == S_XFER) && op_sm_q;
    assign mem.mem_addr = (state_q == S_XFER) ? (base_q + offset_q) : '0;
    assign reg_addr     = (state_q == S_XFER) ? low_idx : '0;
    assign rf_we        = beat_ack && !op_sm_q;
    assign done         = (state_q == S_DONE) && !flush;
    assign xfer_count   = count_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: default 16-bit/8-reg instance plus a 32-bit/16-reg variant,
// checked every cycle against a transaction-level model and by directed literal expectations.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i [2];
    logic        flush_i [2];
    logic        ack_i   [2];
    logic [31:0] ir_i    [2];
    logic [31:0] base_i  [2];
    logic        chk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lm_sm_sequencer_if #(.DATA_W(16)) if0 ();
    lm_sm_sequencer_if #(.DATA_W(32)) if1 ();
    assign if0.mem_ack = ack_i[0];
    assign if1.mem_ack = ack_i[1];

    wire        ready_o [2];
    wire        busy_o  [2];
    wire        rfwe_o  [2];
    wire        done_o  [2];
    wire [2:0]  reg0;
    wire [3:0]  reg1;
    wire [3:0]  cnt0;
    wire [4:0]  cnt1;
    wire [31:0] reg_o  [2];
    wire [31:0] cnt_o  [2];
    wire [31:0] addr_o [2];
    wire        req_o  [2];
    wire        we_o   [2];

    assign reg_o[0]  = {29'd0, reg0};
    assign reg_o[1]  = {28'd0, reg1};
    assign cnt_o[0]  = {28'd0, cnt0};
    assign cnt_o[1]  = {27'd0, cnt1};
    assign addr_o[0] = {16'd0, if0.mem_addr};
    assign addr_o[1] = if1.mem_addr;
    assign req_o[0]  = if0.mem_req;
    assign req_o[1]  = if1.mem_req;
    assign we_o[0]   = if0.mem_we;
    assign we_o[1]   = if1.mem_we;

    lm_sm_sequencer #(.DATA_W(16), .NREGS(8), .REG_AW(3)) dut0 (
        .clk(clk), .rst(rst), .start(start_i[0]), .ir(ir_i[0][15:0]),
        .base_addr(base_i[0][15:0]), .flush(flush_i[0]), .ready(ready_o[0]),
        .busy(busy_o[0]), .mem(if0.master), .reg_addr(reg0), .rf_we(rfwe_o[0]),
        .done(done_o[0]), .xfer_count(cnt0)
    );

    lm_sm_sequencer #(.DATA_W(32), .NREGS(16), .REG_AW(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_i[1]), .ir(ir_i[1]),
        .base_addr(base_i[1]), .flush(flush_i[1]), .ready(ready_o[1]),
        .busy(busy_o[1]), .mem(if1.master), .reg_addr(reg1), .rf_we(rfwe_o[1]),
        .done(done_o[1]), .xfer_count(cnt1)
    );

    // Model: per instance, an idle/transferring/finishing phase, the set of registers still owed,
    // the base address and the number of beats already completed.
    int          m_phase [2];
    logic [31:0] m_mask  [2];
    logic [31:0] m_base  [2];
    int          m_beats [2];
    bit          m_sm    [2];

    function automatic int width_of(int k);
        return (k == 0) ? 16 : 32;
    endfunction

    function automatic int nregs_of(int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic int low_bit(logic [31:0] m);
        for (int i = 0; i < 32; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic checkOutput(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] opc;
        logic [31:0] wmask;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_phase[k] = 0; m_mask[k] = '0; m_base[k] = '0; m_beats[k] = 0; m_sm[k] = 1'b0;
            end else begin
                case (m_phase[k])
                    0: begin
                        opc   = (ir_i[k] >> (width_of(k) - 4)) & 32'hF;
                        wmask = (32'd1 << nregs_of(k)) - 32'd1;
                        if (start_i[k] && !flush_i[k] && (opc == 32'd6 || opc == 32'd7)) begin
                            m_mask[k]  = ir_i[k] & wmask;
                            m_base[k]  = base_i[k];
                            m_sm[k]    = (opc == 32'd7);
                            m_beats[k] = 0;
                            m_phase[k] = (m_mask[k] != 0) ? 1 : 2;
                        end
                    end
                    1: begin
                        if (ack_i[k]) begin
                            m_mask[k][low_bit(m_mask[k])] = 1'b0;
                            m_beats[k]++;
                        end
                        if (flush_i[k])                        m_phase[k] = 0;
                        else if (ack_i[k] && m_mask[k] == 0)   m_phase[k] = 2;
                    end
                    default: m_phase[k] = 0;
                endcase
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] wm;
                bit          xf;
                wm = (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
                xf = (m_phase[k] == 1);
                checkOutput($sformatf("d%0d_ready", k), ready_o[k], m_phase[k] == 0);
                checkOutput($sformatf("d%0d_busy", k),  busy_o[k],  m_phase[k] != 0);
                checkOutput($sformatf("d%0d_req", k),   req_o[k],   xf);
                checkOutput($sformatf("d%0d_we", k),    we_o[k],    xf && m_sm[k]);
                checkOutput($sformatf("d%0d_rfwe", k),  rfwe_o[k],  xf && !m_sm[k] && ack_i[k]);
                checkOutput($sformatf("d%0d_done", k),  done_o[k],  m_phase[k] == 2 && !flush_i[k]);
                checkOutput($sformatf("d%0d_count", k), cnt_o[k],   m_beats[k]);
                if (xf) begin
                    checkOutput($sformatf("d%0d_addr", k), addr_o[k], (m_base[k] + m_beats[k]) & wm);
                    checkOutput($sformatf("d%0d_reg", k),  reg_o[k],  low_bit(m_mask[k]));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic applyStimulus(int k, logic st, logic [31:0] ir, logic [31:0] base,
                                 logic fl, logic ack);
        start_i[k] = st;
        ir_i[k]    = ir;
        base_i[k]  = base;
        flush_i[k] = fl;
        ack_i[k]   = ack;
    endtask

    logic [15:0] sm_exp_addr [8];
    logic [15:0] sm_got_addr [8];
    int          sm_got_reg  [8];
    int          sm_beats;
    bit          sm_done;

    initial begin
        sm_exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
                        16'h0002, 16'h0003, 16'h0004, 16'h0005};
        rst = 1'b0;
        for (int k = 0; k < 2; k++) applyStimulus(k, 0, 0, 0, 0, 0);
        cyc();
        chk_en = 1'b1;
        sample();
        checkOutput("rst_ready", ready_o[0], 1);
        checkOutput("rst_busy",  busy_o[0],  0);
        checkOutput("rst_req",   req_o[0],   0);
        checkOutput("rst_addr",  addr_o[0],  0);
        checkOutput("rst_reg",   reg_o[0],   0);
        checkOutput("rst_count", cnt_o[0],   0);
        checkOutput("rst_done",  done_o[0],  0);
        cyc();
        rst = 1'b1;
        cyc();

        // LM r0,r2 with ack tied high
        applyStimulus(0, 1, 32'h6005, 32'h0100, 0, 1);
        cyc(); start_i[0] = 0;
        sample();
        checkOutput("lm_c1_req",  req_o[0],  1);
        checkOutput("lm_c1_reg",  reg_o[0],  0);
        checkOutput("lm_c1_addr", addr_o[0], 32'h0100);
        checkOutput("lm_c1_rfwe", rfwe_o[0], 1);
        cyc(); sample();
        checkOutput("lm_c2_reg",  reg_o[0],  2);
        checkOutput("lm_c2_addr", addr_o[0], 32'h0101);
        checkOutput("lm_c2_rfwe", rfwe_o[0], 1);
        cyc(); sample();
        checkOutput("lm_c3_done",  done_o[0], 1);
        checkOutput("lm_c3_count", cnt_o[0],  2);
        cyc(); sample();
        checkOutput("lm_c4_ready", ready_o[0], 1);
        cyc();

        // SM all registers, ack every third cycle, address wraps past FFFF
        applyStimulus(0, 1, 32'h70FF, 32'hFFFE, 0, 0);
        cyc(); start_i[0] = 0;
        sm_beats = 0;
        sm_done  = 0;
        for (int t = 0; t < 80; t++) begin
            ack_i[0] = (t % 3 == 2);
            sample();
            if (done_o[0]) begin
                sm_done = 1;
                break;
            end
            if (req_o[0] && ack_i[0] && sm_beats < 8) begin
                sm_got_addr[sm_beats] = addr_o[0][15:0];
                sm_got_reg[sm_beats]  = int'(reg_o[0]);
                sm_beats++;
            end
            cyc();
        end
        checkOutput("sm_done_seen", sm_done, 1);
        checkOutput("sm_beats", sm_beats, 8);
        checkOutput("sm_count", cnt_o[0], 8);
        for (int i = 0; i < sm_beats; i++) begin
            checkOutput($sformatf("sm_addr%0d", i), sm_got_addr[i], sm_exp_addr[i]);
            checkOutput($sformatf("sm_reg%0d", i),  sm_got_reg[i],  i);
        end
        cyc(); ack_i[0] = 0;

        // Empty mask: done only
        applyStimulus(0, 1, 32'h6000, 32'h0200, 0, 1);
        cyc(); start_i[0] = 0;
        sample();
        checkOutput("empty_done",  done_o[0], 1);
        checkOutput("empty_req",   req_o[0],  0);
        checkOutput("empty_count", cnt_o[0],  0);
        cyc();

        // Opcode that is neither LM nor SM is ignored
        applyStimulus(0, 1, 32'h1234, 32'h0000, 0, 1);
        cyc(); start_i[0] = 0;
        sample();
        checkOutput("badopc_ready", ready_o[0], 1);
        checkOutput("badopc_busy",  busy_o[0],  0);
        cyc();

        // Flush in DONE suppresses the done pulse
        applyStimulus(0, 1, 32'h6000, 32'h0000, 0, 1);
        cyc(); start_i[0] = 0; flush_i[0] = 1;
        sample();
        checkOutput("flushdone_done", done_o[0], 0);
        cyc(); flush_i[0] = 0;
        sample();
        checkOutput("flushdone_ready", ready_o[0], 1);
        cyc();

        // Flush during LM after two acks
        applyStimulus(0, 1, 32'h60F0, 32'h0300, 0, 1);
        cyc(); start_i[0] = 0;
        sample();
        checkOutput("fl_c1_reg", reg_o[0], 4);
        cyc(); sample();
        checkOutput("fl_c2_reg",  reg_o[0],  5);
        checkOutput("fl_c2_addr", addr_o[0], 32'h0301);
        cyc(); ack_i[0] = 0; flush_i[0] = 1;
        sample();
        checkOutput("fl_c3_rfwe", rfwe_o[0], 0);
        cyc(); flush_i[0] = 0;
        sample();
        checkOutput("fl_c4_ready", ready_o[0], 1);
        checkOutput("fl_c4_done",  done_o[0],  0);
        checkOutput("fl_c4_count", cnt_o[0],   2);
        cyc(); sample();
        checkOutput("fl_c5_req", req_o[0], 0);
        cyc();

        // Flush in the same cycle as an ack: the beat still completes
        applyStimulus(0, 1, 32'h6003, 32'h0400, 0, 1);
        cyc(); start_i[0] = 0; flush_i[0] = 1;
        sample();
        checkOutput("flack_rfwe", rfwe_o[0], 1);
        checkOutput("flack_reg",  reg_o[0],  0);
        cyc(); flush_i[0] = 0;
        sample();
        checkOutput("flack_ready", ready_o[0], 1);
        checkOutput("flack_count", cnt_o[0],   1);
        cyc();

        // Reset in the middle of a stalled SM
        applyStimulus(0, 1, 32'h70FF, 32'h0500, 0, 0);
        cyc(); start_i[0] = 0;
        cyc(); rst = 1'b0;
        cyc(); rst = 1'b1;
        sample();
        checkOutput("mrst_ready", ready_o[0], 1);
        checkOutput("mrst_busy",  busy_o[0],  0);
        checkOutput("mrst_req",   req_o[0],   0);
        checkOutput("mrst_addr",  addr_o[0],  0);
        checkOutput("mrst_reg",   reg_o[0],   0);
        checkOutput("mrst_count", cnt_o[0],   0);
        checkOutput("mrst_done",  done_o[0],  0);
        cyc();

        // start held high while busy, second instruction taken in the ready cycle
        applyStimulus(0, 1, 32'h6003, 32'h0600, 0, 1);
        cyc(); ir_i[0] = 32'h7001;
        sample();
        checkOutput("b2b_c1_we", we_o[0], 0);
        cyc(); cyc(); sample();
        checkOutput("b2b_c3_done", done_o[0], 1);
        cyc(); sample();
        checkOutput("b2b_c4_ready", ready_o[0], 1);
        cyc(); start_i[0] = 0;
        sample();
        checkOutput("b2b_c5_req",  req_o[0],  1);
        checkOutput("b2b_c5_we",   we_o[0],   1);
        checkOutput("b2b_c5_addr", addr_o[0], 32'h0600);
        cyc(); sample();
        checkOutput("b2b_c6_done",  done_o[0], 1);
        checkOutput("b2b_c6_count", cnt_o[0],  1);
        cyc(); ack_i[0] = 0;

        // Wide variant: mask 0x8001 gives r0 then r15
        applyStimulus(1, 1, 32'h6000_8001, 32'h1000_0000, 0, 1);
        cyc(); start_i[1] = 0;
        sample();
        checkOutput("w_c1_reg",  reg_o[1],  0);
        checkOutput("w_c1_addr", addr_o[1], 32'h1000_0000);
        cyc(); sample();
        checkOutput("w_c2_reg",  reg_o[1],  15);
        checkOutput("w_c2_addr", addr_o[1], 32'h1000_0001);
        cyc(); sample();
        checkOutput("w_c3_done",  done_o[1], 1);
        checkOutput("w_c3_count", cnt_o[1],  2);
        cyc(); cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
